// File: rtl/mem_arbiter_pkg.sv
// ----------------------------------------------------------------------------
// mem_arbiter_pkg
//   Shared types and defaults for the instruction/data memory arbiter.
//   - arbState_t : arbiter FSM state (IDLE/ADDR/DATA), exposed on the debug port
//   - grant_t    : which requester currently owns the memory port
//   - DEFAULT_TIMEOUT / DEFAULT_CW : watchdog defaults
// ----------------------------------------------------------------------------
package mem_arbiter_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      ADDR = 2'd1,
      DATA = 2'd2
   } arbState_t;

   typedef enum logic [1:0] {
      NONE = 2'd0,
      GI   = 2'd1,
      GD   = 2'd2
   } grant_t;

   localparam int DEFAULT_TIMEOUT = 255;
   localparam int DEFAULT_CW      = 8;

   // True while a transaction owns the memory port.
   function automatic logic isBusy(arbState_t s);
      return (s == ADDR) || (s == DATA);
   endfunction

endpackage

// File: rtl/mem_arbiter_wdog.sv
// ----------------------------------------------------------------------------
// arb_wdog
//   Transaction watchdog for mem_arbiter. Counts cycles spent by the current
//   transaction and flags the cycle in which the budget runs out.
//
//   Ports:
//     clk     in   clock
//     rst     in   asynchronous active-low reset
//     clear   in   restart the count (new transaction granted)
//     enable  in   a transaction is in progress this cycle
//     expire  out  this is the TIMEOUT-th busy cycle; the owner aborts at the
//                  coming edge so the abort is visible in the next cycle
// ----------------------------------------------------------------------------
module arb_wdog
   import mem_arbiter_pkg::*;
#(
   parameter int CW      = DEFAULT_CW,
   parameter int TIMEOUT = DEFAULT_TIMEOUT   // legal range 1 .. 2**CW-1
) (
   input  logic clk,
   input  logic rst,
   input  logic clear,
   input  logic enable,
   output logic expire
);

   // Expire is raised on the busy cycle that would make the count reach
   // TIMEOUT, so a transaction never occupies more than TIMEOUT busy cycles.
   localparam logic [CW-1:0] LAST = CW'(TIMEOUT - 1);

   logic [CW-1:0] count;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         count <= '0;
      end else if (clear) begin
         count <= '0;
      end else if (enable) begin
         count <= count + CW'(1);
      end
   end

   assign expire = enable && (count == LAST);

endmodule

// File: rtl/mem_arbiter.sv
// ----------------------------------------------------------------------------
// mem_arbiter
//   Shares one SRAM-like memory port between the fetch requester (I) and the
//   memory-stage requester (D). One transaction in flight at a time, fixed
//   priority D > I, combinational pipeline stall, and a watchdog that aborts a
//   transaction the memory never finishes.
//
//   Handshakes:
//     Requester side: req is raised and held (with stable address/data) until
//     the matching ok pulse; ok is a single-cycle registered completion pulse
//     and rdata is updated in that same cycle for reads. A request whose ok is
//     high in the current cycle is not eligible for a new grant, so a held req
//     is re-granted one cycle after its ok.
//     Memory side: mem_req and all mem_* fields are registered and held until
//     mem_addr_ok is seen; completion is mem_data_ok (with mem_rdata), which may
//     coincide with mem_addr_ok. mem_data_ok outside a transaction is ignored.
//
//   Ports:
//     clk, rst                       clock, asynchronous active-low reset
//     inst_req/inst_addr             I request and address
//     inst_rdata/inst_ok             I read data (held) and completion pulse
//     data_req/data_wr/data_wstrb    D request, write flag, byte enables
//     data_addr/data_wdata           D address and write data
//     data_rdata/data_ok             D read data (held) and completion pulse
//     mem_req/mem_wr/mem_wstrb       registered memory request fields
//     mem_addr/mem_wdata
//     mem_addr_ok/mem_data_ok        memory address accept / completion
//     mem_rdata                      memory read data, valid with mem_data_ok
//     stall                          an unserved request is present
//     err                            one-cycle watchdog abort pulse
//     dbgState/dbgGrant              current FSM state and grant owner
// ----------------------------------------------------------------------------
module mem_arbiter
   import mem_arbiter_pkg::*;
#(
   parameter int AW      = 32,
   parameter int DW      = 32,
   parameter int TIMEOUT = DEFAULT_TIMEOUT,
   parameter int CW      = DEFAULT_CW
) (
   input  logic            clk,
   input  logic            rst,

   input  logic            inst_req,
   input  logic [AW-1:0]   inst_addr,
   output logic [DW-1:0]   inst_rdata,
   output logic            inst_ok,

   input  logic            data_req,
   input  logic            data_wr,
   input  logic [DW/8-1:0] data_wstrb,
   input  logic [AW-1:0]   data_addr,
   input  logic [DW-1:0]   data_wdata,
   output logic [DW-1:0]   data_rdata,
   output logic            data_ok,

   output logic            mem_req,
   output logic            mem_wr,
   output logic [DW/8-1:0] mem_wstrb,
   output logic [AW-1:0]   mem_addr,
   output logic [DW-1:0]   mem_wdata,
   input  logic            mem_addr_ok,
   input  logic            mem_data_ok,
   input  logic [DW-1:0]   mem_rdata,

   output logic            stall,
   output logic            err,

   output arbState_t       dbgState,
   output grant_t          dbgGrant
);

   arbState_t state;
   grant_t    grant;

   logic instElig;
   logic dataElig;
   logic grantNow;
   logic memDone;
   logic wdogExpire;
   logic wdogAbort;
   logic finishing;
   logic [DW-1:0] completeData;

   // A requester whose ok is pulsing this cycle is finishing, not asking again.
   assign instElig = inst_req & ~inst_ok;
   assign dataElig = data_req & ~data_ok;

   // Stall is purely combinational so the pipeline freezes in the same cycle
   // a request appears; it is held low while reset is asserted.
   assign stall = rst & (instElig | dataElig);

   assign grantNow = (state == IDLE) && (instElig || dataElig);

   // Completion needs the address phase accepted: either already in DATA, or
   // address and data accepted together in ADDR.
   assign memDone = ((state == DATA) && mem_data_ok) ||
                    ((state == ADDR) && mem_addr_ok && mem_data_ok);

   // A real completion in the expiry cycle wins over the abort.
   assign wdogAbort    = wdogExpire && !memDone;
   assign finishing    = memDone || wdogAbort;
   assign completeData = wdogAbort ? '0 : mem_rdata;

   arb_wdog #(
      .CW      (CW),
      .TIMEOUT (TIMEOUT)
   ) uWdog (
      .clk    (clk),
      .rst    (rst),
      .clear  (grantNow),
      .enable (isBusy(state)),
      .expire (wdogExpire)
   );

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state      <= IDLE;
         grant      <= NONE;
         mem_req    <= 1'b0;
         mem_wr     <= 1'b0;
         mem_wstrb  <= '0;
         mem_addr   <= '0;
         mem_wdata  <= '0;
         inst_ok    <= 1'b0;
         data_ok    <= 1'b0;
         err        <= 1'b0;
         inst_rdata <= '0;
         data_rdata <= '0;
      end else begin
         // Completion and abort indications are single-cycle pulses.
         inst_ok <= 1'b0;
         data_ok <= 1'b0;
         err     <= 1'b0;

         unique case (state)
            IDLE: begin
               if (dataElig) begin
                  grant     <= GD;
                  mem_req   <= 1'b1;
                  mem_wr    <= data_wr;
                  mem_wstrb <= data_wstrb;
                  mem_addr  <= data_addr;
                  mem_wdata <= data_wdata;
                  state     <= ADDR;
               end else if (instElig) begin
                  // Fetches are always reads with no byte lanes enabled.
                  grant     <= GI;
                  mem_req   <= 1'b1;
                  mem_wr    <= 1'b0;
                  mem_wstrb <= '0;
                  mem_addr  <= inst_addr;
                  mem_wdata <= '0;
                  state     <= ADDR;
               end
            end

            ADDR, DATA: begin
               if (finishing) begin
                  mem_req <= 1'b0;
                  state   <= IDLE;
                  grant   <= NONE;
                  err     <= wdogAbort;
                  if (grant == GD) begin
                     data_ok <= 1'b1;
                     // Writes leave the last read value untouched.
                     if (!mem_wr) begin
                        data_rdata <= completeData;
                     end
                  end else if (grant == GI) begin
                     inst_ok    <= 1'b1;
                     inst_rdata <= completeData;
                  end
               end else if ((state == ADDR) && mem_addr_ok) begin
                  mem_req <= 1'b0;
                  state   <= DATA;
               end
            end

            default: begin
               state   <= IDLE;
               grant   <= NONE;
               mem_req <= 1'b0;
            end
         endcase
      end
   end

   assign dbgState = state;
   assign dbgGrant = grant;

endmodule

// File: tb/tb_mem_arbiter.sv
// ----------------------------------------------------------------------------
// tb_mem_arbiter
//   Directed bench for mem_arbiter (TIMEOUT = 8). Inputs change 1 time unit
//   after each rising edge; outputs are compared 2 units later, well before
//   the falling edge. "Cycle n" below counts from the cycle the request is
//   raised.
// ----------------------------------------------------------------------------
module tb_mem_arbiter;
   import mem_arbiter_pkg::*;

   localparam int AW = 32;
   localparam int DW = 32;

   logic            clk = 1'b0;
   logic            rst = 1'b0;
   logic            inst_req;
   logic [AW-1:0]   inst_addr;
   logic [DW-1:0]   inst_rdata;
   logic            inst_ok;
   logic            data_req;
   logic            data_wr;
   logic [DW/8-1:0] data_wstrb;
   logic [AW-1:0]   data_addr;
   logic [DW-1:0]   data_wdata;
   logic [DW-1:0]   data_rdata;
   logic            data_ok;
   logic            mem_req;
   logic            mem_wr;
   logic [DW/8-1:0] mem_wstrb;
   logic [AW-1:0]   mem_addr;
   logic [DW-1:0]   mem_wdata;
   logic            mem_addr_ok;
   logic            mem_data_ok;
   logic [DW-1:0]   mem_rdata;
   logic            stall;
   logic            err;
   arbState_t       dbgState;
   grant_t          dbgGrant;

   int checkCount = 0;
   int errorCount = 0;
   logic [DW-1:0] expQ[$];

   mem_arbiter #(
      .AW(AW), .DW(DW), .TIMEOUT(8), .CW(8)
   ) dut (
      .clk(clk), .rst(rst),
      .inst_req(inst_req), .inst_addr(inst_addr), .inst_rdata(inst_rdata), .inst_ok(inst_ok),
      .data_req(data_req), .data_wr(data_wr), .data_wstrb(data_wstrb), .data_addr(data_addr),
      .data_wdata(data_wdata), .data_rdata(data_rdata), .data_ok(data_ok),
      .mem_req(mem_req), .mem_wr(mem_wr), .mem_wstrb(mem_wstrb), .mem_addr(mem_addr),
      .mem_wdata(mem_wdata), .mem_addr_ok(mem_addr_ok), .mem_data_ok(mem_data_ok),
      .mem_rdata(mem_rdata), .stall(stall), .err(err),
      .dbgState(dbgState), .dbgGrant(dbgGrant)
   );

   // ---------------- clock ----------------
   always #5 clk = ~clk;

   // ---------------- driver tasks ----------------
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic settle();
      #2;
   endtask

   task automatic idleReq();
      inst_req   = 1'b0;
      inst_addr  = '0;
      data_req   = 1'b0;
      data_wr    = 1'b0;
      data_wstrb = '0;
      data_addr  = '0;
      data_wdata = '0;
   endtask

   task automatic idleMem();
      mem_addr_ok = 1'b0;
      mem_data_ok = 1'b0;
      mem_rdata   = '0;
   endtask

   // ---------------- scenarios ----------------
   task automatic test_reset();
      rst = 1'b0;
      idleReq();
      idleMem();
      inst_req = 1'b1;
      data_req = 1'b1;
      tick(); settle();
      checkCount++; if (stall !== 1'b0) begin errorCount++; $display("FAIL rst_stall: stall=%b expected 0", stall); end
      checkCount++; if (mem_req !== 1'b0) begin errorCount++; $display("FAIL rst_mem_req: mem_req=%b expected 0", mem_req); end
      checkCount++; if ({inst_ok, data_ok, err} !== 3'b000) begin errorCount++; $display("FAIL rst_pulses: ok/ok/err=%b expected 000", {inst_ok, data_ok, err}); end
      checkCount++; if ({mem_wr, mem_wstrb, mem_addr, mem_wdata} !== '0) begin errorCount++; $display("FAIL rst_mem_fields: got %h expected 0", {mem_wr, mem_wstrb, mem_addr, mem_wdata}); end
      checkCount++; if ({inst_rdata, data_rdata} !== '0) begin errorCount++; $display("FAIL rst_rdata: got %h expected 0", {inst_rdata, data_rdata}); end
      checkCount++; if (dbgState !== IDLE || dbgGrant !== NONE) begin errorCount++; $display("FAIL rst_state: state=%0d grant=%0d expected 0/0", dbgState, dbgGrant); end
      idleReq();
      tick();
      rst = 1'b1;
      settle();
      checkCount++; if (mem_req !== 1'b0 || stall !== 1'b0) begin errorCount++; $display("FAIL rst_release: mem_req=%b stall=%b expected 0/0", mem_req, stall); end
   endtask

   task automatic test_inst_read();
      tick(); inst_req = 1'b1; inst_addr = 32'hBFC0_0000; settle();                 // cycle 0
      checkCount++; if (stall !== 1'b1) begin errorCount++; $display("FAIL ird_stall_c0: stall=%b expected 1", stall); end
      checkCount++; if (mem_req !== 1'b0) begin errorCount++; $display("FAIL ird_memreq_c0: mem_req=%b expected 0", mem_req); end
      tick(); mem_addr_ok = 1'b1; settle();                                          // cycle 1
      checkCount++; if (mem_req !== 1'b1 || mem_addr !== 32'hBFC0_0000 || mem_wr !== 1'b0) begin errorCount++; $display("FAIL ird_issue_c1: req=%b addr=%h wr=%b expected 1/bfc00000/0", mem_req, mem_addr, mem_wr); end
      checkCount++; if (stall !== 1'b1) begin errorCount++; $display("FAIL ird_stall_c1: stall=%b expected 1", stall); end
      tick(); mem_addr_ok = 1'b0; settle();                                          // cycle 2
      checkCount++; if (mem_req !== 1'b0 || dbgState !== DATA) begin errorCount++; $display("FAIL ird_data_c2: req=%b state=%0d expected 0/2", mem_req, dbgState); end
      checkCount++; if (stall !== 1'b1) begin errorCount++; $display("FAIL ird_stall_c2: stall=%b expected 1", stall); end
      tick(); mem_data_ok = 1'b1; mem_rdata = 32'h3C01_0001; settle();               // cycle 3
      checkCount++; if (inst_ok !== 1'b0 || stall !== 1'b1) begin errorCount++; $display("FAIL ird_c3: ok=%b stall=%b expected 0/1", inst_ok, stall); end
      tick(); idleMem(); settle();                                                   // cycle 4
      checkCount++; if (inst_ok !== 1'b1) begin errorCount++; $display("FAIL ird_ok_c4: inst_ok=%b expected 1", inst_ok); end
      checkCount++; if (inst_rdata !== 32'h3C01_0001) begin errorCount++; $display("FAIL ird_rdata_c4: inst_rdata=%h expected 3c010001", inst_rdata); end
      checkCount++; if (stall !== 1'b0) begin errorCount++; $display("FAIL ird_stall_c4: stall=%b expected 0", stall); end
      inst_req = 1'b0;
      tick(); settle();                                                              // cycle 5
      checkCount++; if (inst_ok !== 1'b0 || mem_req !== 1'b0 || dbgState !== IDLE) begin errorCount++; $display("FAIL ird_after_c5: ok=%b req=%b state=%0d expected 0/0/0", inst_ok, mem_req, dbgState); end
   endtask

   task automatic test_contention();
      tick();                                                                         // cycle 0
      inst_req = 1'b1; inst_addr = 32'h0000_2000;
      data_req = 1'b1; data_wr = 1'b1; data_addr = 32'h0000_0100; data_wdata = 32'h1234_5678; data_wstrb = 4'hF;
      settle();
      checkCount++; if (stall !== 1'b1) begin errorCount++; $display("FAIL con_stall_c0: stall=%b expected 1", stall); end
      tick(); mem_addr_ok = 1'b1; settle();                                           // cycle 1
      checkCount++; if (mem_req !== 1'b1 || mem_wr !== 1'b1 || mem_addr !== 32'h100) begin errorCount++; $display("FAIL con_d_first: req=%b wr=%b addr=%h expected 1/1/00000100", mem_req, mem_wr, mem_addr); end
      checkCount++; if (mem_wdata !== 32'h1234_5678 || mem_wstrb !== 4'hF) begin errorCount++; $display("FAIL con_d_wdata: wdata=%h wstrb=%h expected 12345678/f", mem_wdata, mem_wstrb); end
      tick(); mem_addr_ok = 1'b0; mem_data_ok = 1'b1; mem_rdata = 32'hDEAD_BEEF; settle(); // cycle 2
      checkCount++; if (data_ok !== 1'b0 || inst_ok !== 1'b0) begin errorCount++; $display("FAIL con_early_ok: data_ok=%b inst_ok=%b expected 0/0", data_ok, inst_ok); end
      tick(); idleMem(); settle();                                                     // cycle 3
      checkCount++; if (data_ok !== 1'b1 || inst_ok !== 1'b0) begin errorCount++; $display("FAIL con_d_ok: data_ok=%b inst_ok=%b expected 1/0", data_ok, inst_ok); end
      checkCount++; if (data_rdata !== 32'h0) begin errorCount++; $display("FAIL con_wr_rdata: data_rdata=%h expected 00000000", data_rdata); end
      checkCount++; if (inst_rdata !== 32'h3C01_0001) begin errorCount++; $display("FAIL con_inst_rdata: inst_rdata=%h expected 3c010001", inst_rdata); end
      checkCount++; if (stall !== 1'b1 || mem_req !== 1'b0) begin errorCount++; $display("FAIL con_c3: stall=%b req=%b expected 1/0", stall, mem_req); end
      data_req = 1'b0; data_wr = 1'b0;
      tick(); settle();                                                                // cycle 4
      checkCount++; if (mem_req !== 1'b1 || mem_addr !== 32'h2000 || mem_wr !== 1'b0 || mem_wstrb !== 4'h0) begin errorCount++; $display("FAIL con_i_grant: req=%b addr=%h wr=%b wstrb=%h expected 1/00002000/0/0", mem_req, mem_addr, mem_wr, mem_wstrb); end
      mem_addr_ok = 1'b1; mem_data_ok = 1'b1; mem_rdata = 32'h0BAD_F00D;
      expQ.push_back(32'h0BAD_F00D);
      tick(); idleMem(); settle();                                                     // cycle 5
      checkCount++; if (inst_ok !== 1'b1 || data_ok !== 1'b0) begin errorCount++; $display("FAIL con_i_ok: inst_ok=%b data_ok=%b expected 1/0", inst_ok, data_ok); end
      if (expQ.size() > 0) begin
         logic [DW-1:0] expRdata;
         expRdata = expQ.pop_front();
         checkCount++; if (inst_rdata !== expRdata) begin errorCount++; $display("FAIL con_i_rdata: inst_rdata=%h expected %h", inst_rdata, expRdata); end
      end
      inst_req = 1'b0;
   endtask

   task automatic test_zero_latency();
      logic sawData;
      sawData = 1'b0;
      tick(); data_req = 1'b1; data_wr = 1'b0; data_addr = 32'h0000_0200; settle();   // cycle 0
      sawData = sawData | (dbgState == DATA);
      tick(); settle();                                                                // cycle 1
      sawData = sawData | (dbgState == DATA);
      checkCount++; if (mem_req !== 1'b1 || dbgState !== ADDR || mem_wr !== 1'b0) begin errorCount++; $display("FAIL zl_issue: req=%b state=%0d wr=%b expected 1/1/0", mem_req, dbgState, mem_wr); end
      mem_addr_ok = 1'b1; mem_data_ok = 1'b1; mem_rdata = 32'hA5A5_A5A5;
      tick(); idleMem(); settle();                                                     // cycle 2
      sawData = sawData | (dbgState == DATA);
      checkCount++; if (data_ok !== 1'b1) begin errorCount++; $display("FAIL zl_ok: data_ok=%b expected 1", data_ok); end
      checkCount++; if (data_rdata !== 32'hA5A5_A5A5) begin errorCount++; $display("FAIL zl_rdata: data_rdata=%h expected a5a5a5a5", data_rdata); end
      checkCount++; if (sawData !== 1'b0 || dbgState !== IDLE) begin errorCount++; $display("FAIL zl_no_data_state: sawData=%b state=%0d expected 0/0", sawData, dbgState); end
      data_req = 1'b0;
   endtask

   task automatic test_watchdog();
      logic earlyPulse;
      earlyPulse = 1'b0;
      tick(); data_req = 1'b1; data_wr = 1'b0; data_addr = 32'h0000_0300; settle();   // cycle 0
      for (int c = 1; c <= 7; c++) begin                                               // cycles 1..7
         tick(); settle();
         earlyPulse = earlyPulse | data_ok | err;
      end
      tick(); settle();                                                                // cycle 8
      earlyPulse = earlyPulse | data_ok | err;
      checkCount++; if (earlyPulse !== 1'b0) begin errorCount++; $display("FAIL wd_early: pulse seen=%b expected 0", earlyPulse); end
      checkCount++; if (mem_req !== 1'b1) begin errorCount++; $display("FAIL wd_held_c8: mem_req=%b expected 1", mem_req); end
      tick(); settle();                                                                // cycle 9
      checkCount++; if (data_ok !== 1'b1 || err !== 1'b1) begin errorCount++; $display("FAIL wd_abort_c9: data_ok=%b err=%b expected 1/1", data_ok, err); end
      checkCount++; if (data_rdata !== 32'h0) begin errorCount++; $display("FAIL wd_rdata: data_rdata=%h expected 00000000", data_rdata); end
      checkCount++; if (mem_req !== 1'b0 || dbgState !== IDLE) begin errorCount++; $display("FAIL wd_idle: req=%b state=%0d expected 0/0", mem_req, dbgState); end
      data_req = 1'b0;
      tick(); settle();                                                                // cycle 10
      checkCount++; if (err !== 1'b0 || data_ok !== 1'b0) begin errorCount++; $display("FAIL wd_one_pulse: err=%b data_ok=%b expected 0/0", err, data_ok); end
      mem_data_ok = 1'b1; mem_rdata = 32'hFFFF_0000;                                  // late completion
      tick(); idleMem(); settle();                                                     // cycle 11
      checkCount++; if (data_ok !== 1'b0 || inst_ok !== 1'b0 || data_rdata !== 32'h0) begin errorCount++; $display("FAIL wd_late_ignored: data_ok=%b inst_ok=%b rdata=%h expected 0/0/00000000", data_ok, inst_ok, data_rdata); end
      // Follow-up request is served normally.
      tick(); inst_req = 1'b1; inst_addr = 32'h0000_0400; settle();                   // cycle 0
      tick(); settle();                                                                // cycle 1
      checkCount++; if (mem_req !== 1'b1 || mem_addr !== 32'h400) begin errorCount++; $display("FAIL wd_next_issue: req=%b addr=%h expected 1/00000400", mem_req, mem_addr); end
      mem_addr_ok = 1'b1; mem_data_ok = 1'b1; mem_rdata = 32'h1111_2222;
      tick(); idleMem(); settle();                                                     // cycle 2
      checkCount++; if (inst_ok !== 1'b1 || err !== 1'b0 || inst_rdata !== 32'h1111_2222) begin errorCount++; $display("FAIL wd_next_ok: ok=%b err=%b rdata=%h expected 1/0/11112222", inst_ok, err, inst_rdata); end
      inst_req = 1'b0;
   endtask

   task automatic test_reset_mid();
      tick(); inst_req = 1'b1; inst_addr = 32'h0000_0500; settle();                   // cycle 0
      tick(); mem_addr_ok = 1'b1; settle();                                            // cycle 1
      tick(); mem_addr_ok = 1'b0; settle();                                            // cycle 2
      checkCount++; if (dbgState !== DATA) begin errorCount++; $display("FAIL rm_in_data: state=%0d expected 2", dbgState); end
      rst = 1'b0;
      #1;
      checkCount++; if (mem_req !== 1'b0 || dbgState !== IDLE || mem_addr !== 32'h0) begin errorCount++; $display("FAIL rm_async_clear: req=%b state=%0d addr=%h expected 0/0/00000000", mem_req, dbgState, mem_addr); end
      checkCount++; if (inst_rdata !== 32'h0 || stall !== 1'b0) begin errorCount++; $display("FAIL rm_async_rdata: rdata=%h stall=%b expected 00000000/0", inst_rdata, stall); end
      tick(); rst = 1'b1; settle();                                                    // cycle 3
      checkCount++; if (inst_ok !== 1'b0 || mem_req !== 1'b0 || stall !== 1'b1) begin errorCount++; $display("FAIL rm_release: ok=%b req=%b stall=%b expected 0/0/1", inst_ok, mem_req, stall); end
      tick(); settle();                                                                // cycle 4
      checkCount++; if (mem_req !== 1'b1 || mem_addr !== 32'h500) begin errorCount++; $display("FAIL rm_regrant: req=%b addr=%h expected 1/00000500", mem_req, mem_addr); end
      mem_addr_ok = 1'b1; mem_data_ok = 1'b1; mem_rdata = 32'h55AA_55AA;
      tick(); idleMem(); settle();                                                     // cycle 5
      checkCount++; if (inst_ok !== 1'b1 || inst_rdata !== 32'h55AA_55AA) begin errorCount++; $display("FAIL rm_ok: ok=%b rdata=%h expected 1/55aa55aa", inst_ok, inst_rdata); end
      inst_req = 1'b0;
   endtask

   task automatic test_back_to_back();
      tick(); inst_req = 1'b1; inst_addr = 32'h0000_0600; settle();                   // cycle 0
      tick(); settle();                                                                // cycle 1
      mem_addr_ok = 1'b1; mem_data_ok = 1'b1; mem_rdata = 32'h0000_0066;
      tick(); idleMem(); settle();                                                     // cycle 2
      checkCount++; if (inst_ok !== 1'b1 || inst_rdata !== 32'h66) begin errorCount++; $display("FAIL b2b_first_ok: ok=%b rdata=%h expected 1/00000066", inst_ok, inst_rdata); end
      inst_addr = 32'h0000_0604;                                                       // request stays high
      tick(); settle();                                                                // cycle 3
      checkCount++; if (mem_req !== 1'b0 || inst_ok !== 1'b0 || dbgState !== IDLE) begin errorCount++; $display("FAIL b2b_no_dup: req=%b ok=%b state=%0d expected 0/0/0", mem_req, inst_ok, dbgState); end
      checkCount++; if (stall !== 1'b1) begin errorCount++; $display("FAIL b2b_stall: stall=%b expected 1", stall); end
      tick(); settle();                                                                // cycle 4
      checkCount++; if (mem_req !== 1'b1 || mem_addr !== 32'h604) begin errorCount++; $display("FAIL b2b_regrant: req=%b addr=%h expected 1/00000604", mem_req, mem_addr); end
      mem_addr_ok = 1'b1; mem_data_ok = 1'b1; mem_rdata = 32'h0000_0077;
      tick(); idleMem(); settle();                                                     // cycle 5
      checkCount++; if (inst_ok !== 1'b1 || inst_rdata !== 32'h77) begin errorCount++; $display("FAIL b2b_second_ok: ok=%b rdata=%h expected 1/00000077", inst_ok, inst_rdata); end
      inst_req = 1'b0;
      tick(); settle();                                                                // cycle 6
      checkCount++; if (inst_ok !== 1'b0 || mem_req !== 1'b0) begin errorCount++; $display("FAIL b2b_quiet: ok=%b req=%b expected 0/0", inst_ok, mem_req); end
   endtask

   // ---------------- sequence and report ----------------
   initial begin
      idleReq();
      idleMem();
      test_reset();
      test_inst_read();
      test_contention();
      test_zero_latency();
      test_watchdog();
      test_reset_mid();
      test_back_to_back();
      $display("Simulation finished: %0d checks, %0d errors", checkCount, errorCount);
      $finish;
   end

   initial begin
      #100000;
      $display("FAIL global_timeout: simulation time %0t exceeded limit", $time);
      $fatal(1, "bench time limit reached");
   end

endmodule
